// File: rtl/text_console.sv
// Byte-stream console writer for the 80x25 char/attr text screen in video RAM.
// Handles CR/LF/BS/FF, writes printable bytes, scrolls by copying rows up.
module text_console #(
    parameter logic [17:0] BASE = 18'h1E000,
    parameter int          COLS = 80,
    parameter int          ROWS = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  data,
    input  logic [7:0]  attr,
    input  logic        valid,
    output logic        ready,
    output logic [17:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [10:0] cursor
);
    localparam int CELLS     = COLS * ROWS;
    localparam int BYTES     = 2 * CELLS;
    localparam int ROW_BYTES = 2 * COLS;

    localparam logic [10:0] LAST_POS   = 11'(CELLS - 1);
    localparam logic [10:0] SCROLL_POS = 11'(CELLS - COLS);
    localparam logic [10:0] POS_STEP   = 11'(COLS);
    localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
    localparam logic [11:0] COPY_LAST  = 12'(BYTES - ROW_BYTES - 1);
    localparam logic [11:0] FILL_FIRST = 12'(BYTES - ROW_BYTES);
    localparam logic [11:0] BYTE_LAST  = 12'(BYTES - 1);
    localparam logic [11:0] ROW_OFS    = 12'(ROW_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        WCHR,
        WATR,
        SCRL_RD,
        SCRL_WR,
        FILL,
        CLR
    } state_t;

    state_t      state_q;
    logic [10:0] pos_q;
    logic [6:0]  col_q;
    logic [7:0]  at_q;
    logic [11:0] cnt_q;
    logic        erase_q;
    logic        ready_q;
    logic [17:0] addr_q;
    logic [7:0]  wdata_q;
    logic        we_q;
    logic [10:0] cursor_q;

    function automatic logic [17:0] cell_addr(input logic [10:0] p);
        return BASE + {6'd0, p, 1'b0};
    endfunction

    function automatic logic [17:0] byte_addr(input logic [11:0] n);
        return BASE + {6'd0, n};
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            pos_q    <= '0;
            col_q    <= '0;
            at_q     <= '0;
            cnt_q    <= '0;
            erase_q  <= 1'b0;
            ready_q  <= 1'b1;
            addr_q   <= BASE;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            cursor_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    we_q <= 1'b0;
                    // A low ready in IDLE is the settle cycle after a non-writing control code.
                    if (!ready_q) begin
                        ready_q  <= 1'b1;
                        cursor_q <= pos_q;
                    end else if (valid) begin
                        ready_q <= 1'b0;
                        at_q    <= attr;
                        erase_q <= 1'b0;
                        case (data)
                            8'h0D: begin
                                pos_q <= pos_q - {4'd0, col_q};
                                col_q <= '0;
                            end
                            8'h0A: begin
                                if (pos_q < SCROLL_POS) begin
                                    pos_q <= pos_q + POS_STEP;
                                end else begin
                                    cnt_q   <= '0;
                                    addr_q  <= byte_addr(ROW_OFS);
                                    state_q <= SCRL_RD;
                                end
                            end
                            8'h08: begin
                                if (col_q != 7'd0) begin
                                    pos_q   <= pos_q - 11'd1;
                                    col_q   <= col_q - 7'd1;
                                    erase_q <= 1'b1;
                                    addr_q  <= cell_addr(pos_q - 11'd1);
                                    wdata_q <= 8'h20;
                                    we_q    <= 1'b1;
                                    state_q <= WCHR;
                                end
                            end
                            8'h0C: begin
                                cnt_q   <= '0;
                                addr_q  <= BASE;
                                wdata_q <= 8'h20;
                                we_q    <= 1'b1;
                                state_q <= CLR;
                            end
                            default: begin
                                addr_q  <= cell_addr(pos_q);
                                wdata_q <= data;
                                we_q    <= 1'b1;
                                state_q <= WCHR;
                            end
                        endcase
                    end
                end
                WCHR: begin
                    addr_q  <= addr_q + 18'd1;
                    wdata_q <= at_q;
                    state_q <= WATR;
                end
                WATR: begin
                    we_q <= 1'b0;
                    if (erase_q) begin
                        ready_q  <= 1'b1;
                        cursor_q <= pos_q;
                        state_q  <= IDLE;
                    end else if (pos_q == LAST_POS) begin
                        pos_q    <= SCROLL_POS;
                        col_q    <= '0;
                        cursor_q <= SCROLL_POS;
                        cnt_q    <= '0;
                        addr_q   <= byte_addr(ROW_OFS);
                        state_q  <= SCRL_RD;
                    end else begin
                        pos_q    <= pos_q + 11'd1;
                        col_q    <= (col_q == LAST_COL) ? 7'd0 : col_q + 7'd1;
                        cursor_q <= pos_q + 11'd1;
                        ready_q  <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                SCRL_RD: begin
                    addr_q  <= byte_addr(cnt_q);
                    we_q    <= 1'b1;
                    state_q <= SCRL_WR;
                end
                SCRL_WR: begin
                    if (cnt_q == COPY_LAST) begin
                        cnt_q   <= FILL_FIRST;
                        addr_q  <= byte_addr(FILL_FIRST);
                        wdata_q <= 8'h20;
                        state_q <= FILL;
                    end else begin
                        cnt_q   <= cnt_q + 12'd1;
                        addr_q  <= byte_addr(cnt_q + 12'd1 + ROW_OFS);
                        we_q    <= 1'b0;
                        state_q <= SCRL_RD;
                    end
                end
                FILL, CLR: begin
                    if (cnt_q == BYTE_LAST) begin
                        we_q    <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                        if (state_q == CLR) begin
                            pos_q    <= '0;
                            col_q    <= '0;
                            cursor_q <= '0;
                        end else begin
                            cursor_q <= pos_q;
                        end
                    end else begin
                        cnt_q   <= cnt_q + 12'd1;
                        addr_q  <= byte_addr(cnt_q + 12'd1);
                        wdata_q <= cnt_q[0] ? 8'h20 : at_q;
                    end
                end
                default: begin
                    we_q    <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Copy data comes straight from the RAM's registered read port in the write cycle.
    assign mem_wdata   = (state_q == SCRL_WR) ? mem_rdata : wdata_q;
    assign mem_address = addr_q;
    assign mem_we      = we_q;
    assign ready       = ready_q;
    assign cursor      = cursor_q;

endmodule

// File: tb/tb_text_console.sv
// Randomized bench for text_console: a cell-level screen model predicts the
// screen contents, cursor, busy time and write count of every accepted byte.
module tb_text_console;
    localparam logic [17:0] BASE  = 18'h1E000;
    localparam int          NCELL = 2000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [7:0]  data  = 8'h00;
    logic [7:0]  attr  = 8'h00;
    logic        ready;
    logic [17:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [10:0] cursor;

    text_console dut (
        .clock      (clock),
        .reset      (reset),
        .data       (data),
        .attr       (attr),
        .valid      (valid),
        .ready      (ready),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .cursor     (cursor)
    );

    always #20 clock = ~clock;

    logic [7:0] vram [0:3999];
    logic [7:0] rdata_q = 8'h00;
    assign mem_rdata = rdata_q;
    int total_we = 0;
    int oob      = 0;

    int tests = 0;
    int fails = 0;

    logic [7:0] mchr [0:NCELL-1];
    logic [7:0] matr [0:NCELL-1];
    int m_pos        = 0;
    bit screen_known = 1'b1;
    bit mon_en       = 1'b0;
    int last_busy    = 0;
    int last_we      = 0;
    int txn_no       = 0;

    // Video RAM with registered read; out-of-window writes are tallied.
    initial begin : ram_proc
        int idx;
        forever begin
            @(posedge clock);
            idx = int'(mem_address) - int'(BASE);
            if (mem_we) begin
                total_we++;
                if (idx >= 0 && idx < 4000) vram[idx] = mem_wdata;
                else oob++;
            end
            rdata_q <= (idx >= 0 && idx < 4000) ? vram[idx] : 8'h00;
        end
    end

    // Whenever the console is idle its cursor must match the model.
    initial begin : cmp_proc
        forever begin
            @(negedge clock);
            if (mon_en && !reset && ready) begin
                tests++;
                if (int'(cursor) != m_pos) begin
                    fails++;
                    $display("FAIL cursor_idle: cursor=%0d expected %0d", cursor, m_pos);
                end
            end
        end
    end

    initial begin : watchdog
        #(40 * 95000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic m_scroll(input logic [7:0] a);
        for (int c = 0; c < NCELL - 80; c++) begin
            mchr[c] = mchr[c+80];
            matr[c] = matr[c+80];
        end
        for (int c = NCELL - 80; c < NCELL; c++) begin
            mchr[c] = 8'h20;
            matr[c] = a;
        end
    endtask

    task automatic m_apply(input logic [7:0] d, input logic [7:0] a,
                           output int busy, output int wes);
        busy = 1;
        wes  = 0;
        case (d)
            8'h0D: m_pos = m_pos - (m_pos % 80);
            8'h0A: begin
                if (m_pos + 80 < NCELL) m_pos = m_pos + 80;
                else begin
                    m_scroll(a);
                    busy = 7840;
                    wes  = 4000;
                end
            end
            8'h08: begin
                if (m_pos % 80 != 0) begin
                    m_pos = m_pos - 1;
                    mchr[m_pos] = 8'h20;
                    matr[m_pos] = a;
                    busy = 2;
                    wes  = 2;
                end
            end
            8'h0C: begin
                for (int c = 0; c < NCELL; c++) begin
                    mchr[c] = 8'h20;
                    matr[c] = a;
                end
                m_pos = 0;
                busy  = 4000;
                wes   = 4000;
            end
            default: begin
                mchr[m_pos] = d;
                matr[m_pos] = a;
                m_pos = m_pos + 1;
                busy  = 2;
                wes   = 2;
                if (m_pos == NCELL) begin
                    m_scroll(a);
                    m_pos = NCELL - 80;
                    busy  = busy + 7840;
                    wes   = wes + 4000;
                end
            end
        endcase
    endtask

    task automatic check_screen();
        int bad;
        bad = -1;
        for (int k = 0; k < NCELL; k++)
            if (bad < 0 && (vram[2*k] !== mchr[k] || vram[2*k+1] !== matr[k])) bad = k;
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL screen: cell %0d holds %02h/%02h expected %02h/%02h",
                     bad, vram[2*bad], vram[2*bad+1], mchr[bad], matr[bad]);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] a);
        int exp_busy, exp_we, busy, we0, w;
        @(negedge clock);
        w = 0;
        while (!ready && w < 20000) begin
            @(negedge clock);
            w++;
        end
        if (!ready) begin
            chk("ready_wait", int'(ready), 1);
            return;
        end
        data  = d;
        attr  = a;
        valid = 1'b1;
        @(posedge clock);
        #1;
        valid = 1'b0;
        we0 = total_we;
        m_apply(d, a, exp_busy, exp_we);
        busy = 0;
        @(negedge clock);
        while (!ready && busy < 20000) begin
            busy++;
            @(negedge clock);
        end
        last_busy = busy;
        last_we   = total_we - we0;
        txn_no++;
        $display("[TB] txn %0d: data=%02h attr=%02h cursor=%0d busy=%0d writes=%0d",
                 txn_no, d, a, cursor, busy, last_we);
        chk("busy_cycles", busy, exp_busy);
        chk("write_count", last_we, exp_we);
        chk("cursor", int'(cursor), m_pos);
        if (screen_known) check_screen();
    endtask

    initial begin : main
        int n_ok;
        int ff_cnt;
        int r;
        logic [7:0] d;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_ready", int'(ready), 1);
        chk("reset_we", int'(mem_we), 0);
        chk("reset_addr", int'(mem_address), int'(BASE));
        chk("reset_wdata", int'(mem_wdata), 0);
        chk("reset_cursor", int'(cursor), 0);

        for (int k = 0; k < NCELL; k++) begin
            vram[2*k]   = 8'(k);
            vram[2*k+1] = ~8'(k);
            mchr[k]     = 8'(k);
            matr[k]     = ~8'(k);
        end
        m_pos  = 0;
        mon_en = 1'b1;

        // Walk to cell 1999 and let one printable byte trigger a scroll.
        for (int j = 0; j < 24; j++) send(8'h0A, 8'($urandom));
        for (int j = 0; j < 79; j++) send(8'(8'h61 + j % 26), 8'($urandom));
        chk("pre_scroll_cursor", int'(cursor), 1999);
        send(8'h5A, 8'h1F);
        chk("scroll_cell1919_chr", int'(vram[2*1919]), 8'h5A);
        chk("scroll_cell1919_attr", int'(vram[2*1919+1]), 8'h1F);
        chk("scroll_cell0_chr", int'(vram[0]), 8'h50);
        chk("scroll_cell0_attr", int'(vram[1]), 8'hAF);
        n_ok = 0;
        for (int k = 1920; k < NCELL; k++)
            if (vram[2*k] == 8'h20 && vram[2*k+1] == 8'h1F) n_ok++;
        chk("scroll_blank_row", n_ok, 80);
        chk("scroll_cursor", int'(cursor), 1920);
        chk("scroll_busy", last_busy, 2 + 7680 + 160);

        @(negedge clock);
        #5;
        reset = 1'b1;
        m_pos = 0;
        @(posedge clock);
        #1 reset = 1'b0;
        send(8'h41, 8'h17);
        chk("first_chr", int'(vram[0]), 8'h41);
        chk("first_attr", int'(vram[1]), 8'h17);
        chk("first_writes", last_we, 2);
        chk("first_busy", last_busy, 2);
        chk("first_cursor", int'(cursor), 1);

        for (int j = 0; j < 4; j++) send(8'(8'h62 + j), 8'h17);
        send(8'h0A, 8'h17);
        chk("lf_cursor_85", int'(cursor), 85);
        send(8'h0D, 8'h17);
        chk("cr_cursor", int'(cursor), 80);
        chk("cr_writes", last_we, 0);
        send(8'h08, 8'h11);
        chk("bs_col0_cursor", int'(cursor), 80);
        chk("bs_col0_writes", last_we, 0);
        send(8'h78, 8'h22);
        send(8'h08, 8'h4E);
        chk("bs_cursor", int'(cursor), 80);
        chk("bs_erase_chr", int'(vram[160]), 8'h20);
        chk("bs_erase_attr", int'(vram[161]), 8'h4E);
        send(8'h0A, 8'h17);
        chk("lf_cursor_160", int'(cursor), 160);
        chk("lf_writes", last_we, 0);

        send(8'h0C, 8'h07);
        n_ok = 0;
        for (int k = 0; k < NCELL; k++)
            if (vram[2*k] == 8'h20 && vram[2*k+1] == 8'h07) n_ok++;
        chk("ff_cells", n_ok, 2000);
        chk("ff_cursor", int'(cursor), 0);
        chk("ff_busy", last_busy, 4000);

        ff_cnt = 0;
        for (int t = 0; t < 150; t++) begin
            r = int'($urandom_range(0, 99));
            d = 8'($urandom_range(0, 255));
            if (d == 8'h08 || d == 8'h0A || d == 8'h0C || d == 8'h0D) d = 8'h2A;
            if (r >= 55 && r < 72) d = 8'h0A;
            else if (r >= 72 && r < 80) d = 8'h0D;
            else if (r >= 80 && r < 95) d = 8'h08;
            else if (r >= 95 && ff_cnt < 2) begin
                d = 8'h0C;
                ff_cnt++;
            end
            send(d, 8'($urandom));
        end

        // Interrupt an LF-triggered scroll partway through the copy.
        send(8'h0D, 8'h33);
        for (int j = 0; j < 25 && m_pos + 80 < NCELL; j++) send(8'h0A, 8'h33);
        @(negedge clock);
        data  = 8'h0A;
        attr  = 8'h33;
        valid = 1'b1;
        @(posedge clock);
        #1 valid = 1'b0;
        repeat (2000) @(posedge clock);
        @(negedge clock);
        chk("midscroll_busy", int'(ready), 0);
        #5;
        reset = 1'b1;
        m_pos = 0;
        screen_known = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("midreset_we", int'(mem_we), 0);
        chk("midreset_cursor", int'(cursor), 0);
        chk("midreset_ready", int'(ready), 1);
        chk("midreset_addr", int'(mem_address), int'(BASE));
        send(8'h41, 8'h17);
        chk("after_reset_chr", int'(vram[0]), 8'h41);
        chk("after_reset_attr", int'(vram[1]), 8'h17);
        chk("after_reset_writes", last_we, 2);

        chk("oob_writes", oob, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/text_console.md
# text_console

Character-stream writer for the 80×25 text screen that the video scanout block reads. It accepts one byte at a time over a valid/ready handshake and interprets control codes (CR, LF, BS, FF). Printable characters are written as char/attribute pairs into the text area of video memory, and the screen scrolls up when output runs past the last row. It drives the `cursor` index that the scanout block uses for the blinking underline. It owns a dedicated write port of the dual-port video RAM; scanout uses the other port, so no arbitration is needed.

## Interface
- `BASE`, 18'h1E000: byte address of cell 0 char. Cell n: char at BASE+2n, attr at BASE+2n+1.
- `COLS`, 80: columns per row.
- `ROWS`, 25: rows; CELLS = COLS*ROWS = 2000.

Ports:
- `clock` in 1: system clock, 25 MHz.
- `reset` in 1: synchronous, active-high.
- `data` in 8: input byte.
- `attr` in 8: attribute sampled together with `data` on acceptance.
- `valid` in 1: `data`/`attr` present.
- `ready` out 1: byte accepted on a cycle with `valid && ready`.
- `mem_address` out 18: byte address into video RAM.
- `mem_wdata` out 8: write data.
- `mem_we` out 1: write strobe, one byte per cycle.
- `mem_rdata` in 8: read data, valid one cycle after the address (registered RAM).
- `cursor` out 11: cell index of next write, 0..1999.

## Operation
- Registers: `pos` (11 b, 0..1999), `col` (7 b, 0..79), latched `chr`/`at`, copy/fill counter (12 b).
- States: IDLE, WCHR, WATR, SCRL_RD, SCRL_WR, FILL, CLR.
- IDLE, `ready`=1. On acceptance, latch `data`→`chr` and `attr`→`at`; `ready` drops the next cycle.
- 0x0D CR: `pos`-=`col`, `col`=0 → IDLE. No memory write.
- 0x0A LF: if `pos`+80<2000, `pos`+=80 → IDLE. Otherwise go to SCRL_RD; `pos` is unchanged (row 24 after the scroll).
- 0x08 BS:
  - If `col`==0, no-op → IDLE.
  - Otherwise `pos`--, `col`--, `chr`=0x20 → WCHR (erases the cell).
  - The post-write advance is suppressed for BS.
- 0x0C FF: → CLR. Counter=0. Writes 0x20/`at` to all 4000 bytes (even=0x20, odd=`at`), one byte per cycle. Then `pos`=0, `col`=0 → IDLE.
- Any other byte is printable, including 0x00–0x1F not listed above.
  - WCHR writes `chr` at BASE+2·pos.
  - WATR writes `at` at BASE+2·pos+1.
  - Then advance: `col`++, `pos`++. If `col` reaches 80, `col`=0.
  - If `pos` reaches 2000, `pos`=1920 and `col`=0, then → SCRL_RD; else → IDLE.
- Scroll copies bytes 160..3999 down to 0..3839, counter i=0..3839:
  - SCRL_RD: address=BASE+i+160, we=0.
  - SCRL_WR: address=BASE+i, wdata=`mem_rdata`, we=1, i++.
  - After i=3839 → FILL.
  - FILL writes bytes 3840..3999 alternating 0x20/`at`, one per cycle → IDLE.
- LF-triggered scroll uses the `at` latched with the LF byte.
- All address arithmetic is 18-bit unsigned, with no wrap beyond the 4000-byte window.

## Timing
- Reset values:
  - `ready`=1, `mem_we`=0, `mem_address`=BASE, `mem_wdata`=0.
  - `cursor`=0, `pos`=`col`=0, state IDLE.
  - Video RAM contents are not touched.
- Reset in any state (including mid-scroll or mid-clear): the next cycle has `mem_we`=0 and the reset values above. A partial scroll is left as-is.
- Printable byte accepted at cycle 0:
  - c1 WCHR (`mem_we`=1).
  - c2 WATR (`mem_we`=1).
  - c3 IDLE, `ready`=1, `cursor` updated.
  - Throughput is one char per 3 cycles.
- CR/LF without scroll, BS at col 0: `ready` low 1 cycle, `cursor` valid at c2.
- BS with erase: same timing as a printable byte.
- Scroll: 7680 cycles (SCRL_RD/SCRL_WR pairs) + 160 (FILL). `ready` stays low throughout.
- FF: 4000 cycles of CLR.
- `cursor` = `pos` registered. It only changes on transitions into IDLE, plus the `pos`=1920 update before a scroll.
- `mem_we` is high only in WCHR, WATR, SCRL_WR, FILL and CLR.

## Test plan
- Reset, send 0x41 with attr 0x17 → byte 0x1E000=0x41, byte 0x1E001=0x17, `mem_we` high exactly 2 cycles, `cursor`=1, `ready` back at c3.
- `cursor`=85, send 0x0D → `cursor`=80, no writes; then send 0x0A → `cursor`=160, no writes.
- `cursor`=80, send 0x08 → unchanged, no write. At `cursor`=81, send 0x08 → `cursor`=80, bytes 160/161=0x20/attr.
- Preload cell k with char k&0xFF. At `cursor`=1999, send 0x5A with attr 0x1F:
  - Cell 1919 holds 0x5A/0x1F; cell 0 holds former cell 80; cells 1920..1999 hold 0x20/0x1F.
  - `cursor`=1920.
  - `ready` low for 2+7680+160 cycles.
- Send 0x0C with attr 0x07 → all 2000 cells 0x20/0x07, `cursor`=0, `ready` low 4000 cycles.
- Assert `reset` mid-scroll (i≈1000) → next cycle `mem_we`=0, `cursor`=0, `ready`=1. A following 0x41 is written at 0x1E000.
